// File: rtl/fsqrt_pipe_if.sv
// fsqrt_pipe_if: operand/result handshake bundle for the pipelined
// square root, with the tag side-channel on both sides.
interface fsqrt_pipe_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      x;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      res;
    logic [TAG_W-1:0] out_tag;
    logic             invalid;

    modport slave (
        input  in_valid, x, in_tag, out_ready,
        output in_ready, out_valid, res, out_tag, invalid
    );

    modport master (
        output in_valid, x, in_tag, out_ready,
        input  in_ready, out_valid, res, out_tag, invalid
    );
endinterface

// File: rtl/fsqrt_pipe.sv
// fsqrt_pipe: pipelined IEEE-754 single sqrt, restoring digit
// recurrence with valid/ready flow control and a tag side-channel.
module fsqrt_pipe #(
    parameter int STAGES = 8,
    parameter int TAG_W  = 4
) (
    input logic         clk,
    input logic         rstn,
    fsqrt_pipe_if.slave io
);
    localparam int K = 24 / STAGES;

    typedef struct packed {
        logic             spec;
        logic             inv;
        logic [31:0]      sres;
        logic [8:0]       er;
        logic [47:0]      rad;
        logic [23:0]      q;
        logic [25:0]      rem;
        logic [TAG_W-1:0] tag;
    } st_t;

    st_t         d [0:STAGES];
    logic [STAGES:0] v;
    logic [STAGES:0] adv;
    logic        sp_free;
    logic        in_rdy;

    logic             ov;
    logic [31:0]      ores;
    logic [TAG_W-1:0] otag;
    logic             oinv;

    function automatic st_t unpack(
        input logic [31:0]      a,
        input logic [TAG_W-1:0] t
    );
        st_t        u;
        logic [23:0] m24;
        logic       zero, nan, neg, inf;
        u     = '0;
        u.tag = t;
        m24   = {1'b1, a[22:0]};
        u.er  = (({1'b0, a[30:23]} + 9'd1) >> 1) + 9'd63;
        u.rad = a[23] ? {1'b0, m24, 23'b0} : {m24, 24'b0};
        zero  = a[30:23] == 8'd0;
        nan   = a[30:23] == 8'hFF && a[22:0] != 23'd0;
        neg   = a[31] && !zero && !nan;
        inf   = !a[31] && a[30:23] == 8'hFF && a[22:0] == 23'd0;
        unique case (1'b1)
            zero: begin
                u.spec = 1'b1;
                u.sres = {a[31], 31'b0};
            end
            nan, neg: begin
                u.spec = 1'b1;
                u.inv  = 1'b1;
                u.sres = 32'h7FC0_0000;
            end
            inf: begin
                u.spec = 1'b1;
                u.sres = 32'h7F80_0000;
            end
            default: ;
        endcase
        return u;
    endfunction

    // K root bits per stage; radicand consumed two bits per step
    function automatic st_t step(input st_t a);
        st_t         b;
        logic [27:0] r4;
        logic [27:0] t;
        b = a;
        for (int k = 0; k < K; k++) begin
            r4    = {b.rem, b.rad[47:46]};
            t     = r4 - {2'b0, b.q, 2'b01};
            b.rad = {b.rad[45:0], 2'b00};
            if (!t[27]) begin
                b.rem = t[25:0];
                b.q   = {b.q[22:0], 1'b1};
            end else begin
                b.rem = r4[25:0];
                b.q   = {b.q[22:0], 1'b0};
            end
        end
        return b;
    endfunction

    // rem > q means sqrt lies above q+0.5; never exactly halfway
    function automatic logic [31:0] pack(input st_t a);
        logic [24:0] q1;
        logic [7:0]  e8;
        q1 = {1'b0, a.q} + {24'd0, (a.rem > {2'b00, a.q})};
        e8 = a.er[7:0];
        if (a.spec)
            return a.sres;
        else if (q1[24])
            return {1'b0, e8 + 8'd1, 23'd0};
        else
            return {1'b0, e8, q1[22:0]};
    endfunction

    always_comb begin
        logic nf;
        sp_free = !ov || io.out_ready;
        nf      = sp_free;
        adv     = '0;
        for (int i = STAGES; i >= 0; i--) begin
            adv[i] = v[i] && nf;
            nf     = !v[i] || nf;
        end
        in_rdy = nf;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v    <= '0;
            ov   <= 1'b0;
            ores <= '0;
            otag <= '0;
            oinv <= 1'b0;
            for (int i = 0; i <= STAGES; i++)
                d[i] <= '0;
        end else begin
            if (in_rdy)
                v[0] <= io.in_valid;
            if (io.in_valid && in_rdy)
                d[0] <= unpack(io.x, io.in_tag);
            for (int i = 1; i <= STAGES; i++) begin
                if (!v[i] || adv[i])
                    v[i] <= adv[i-1];
                if (adv[i-1])
                    d[i] <= step(d[i-1]);
            end
            if (sp_free)
                ov <= v[STAGES];
            if (adv[STAGES]) begin
                ores <= pack(d[STAGES]);
                otag <= d[STAGES].tag;
                oinv <= d[STAGES].inv;
            end
        end
    end

    assign io.in_ready  = in_rdy;
    assign io.out_valid = ov;
    assign io.res       = ores;
    assign io.out_tag   = otag;
    assign io.invalid   = oinv;
endmodule
